gf2_tile_mv_ctrl: RTL and testbench

//  Sequencer computing y = H*x over GF(2) (AND/XOR) for H of M x N, M=TILE_R*ROW_TILES, N=TILE_C*COL_TILES.

---
 rtl/gf2_tile_mv_ctrl.sv | 145 ++++++++++++++
 tb/tb_gf2_tile_mv_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gf2_tile_mv_ctrl.sv
// GF(2) matrix-vector sequencer: y = H*x, one TILE_R x TILE_C tile of H per clock through a shared AND/XOR core.
// Optional MV_STATS_EN adds saturating completed-result and rejected-write counters.
module gf2_tile_mv_ctrl #(
  parameter int TILE_R    = 4,
  parameter int TILE_C    = 8,
  parameter int ROW_TILES = 2,
  parameter int COL_TILES = 4,
  localparam int M  = TILE_R * ROW_TILES,
  localparam int N  = TILE_C * COL_TILES,
  localparam int T  = ROW_TILES * COL_TILES,
  localparam int AW = (T > 1) ? $clog2(T) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     cfg_we_i,
  input  logic [AW-1:0]            cfg_addr_i,
  input  logic [TILE_R*TILE_C-1:0] cfg_wdata_i,
  output logic                     cfg_err_o,
  input  logic                     vec_valid_i,
  output logic                     vec_ready_o,
  input  logic [N-1:0]             vec_data_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [M-1:0]             res_data_o,
`ifdef MV_STATS_EN
  output logic                     busy_o,
  output logic [15:0]              stat_cnt_o,
  output logic [15:0]              stat_rej_o
`else
  output logic                     busy_o
`endif
);

  localparam int RW = (ROW_TILES > 1) ? $clog2(ROW_TILES) : 1;
  localparam int CW = (COL_TILES > 1) ? $clog2(COL_TILES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                   state_q;
  logic [RW-1:0]            rt_q;
  logic [CW-1:0]            ct_q;
  logic [AW-1:0]            idx_q;
  logic [TILE_R-1:0]        acc_q;
  logic [M-1:0]             res_data_q;
  logic                     res_valid_q;
  logic                     cfg_err_q;
  logic [N-1:0]             x_q;
  logic [TILE_R*TILE_C-1:0] tile_q [T];

  logic                     cfg_ok;
  logic [TILE_R*TILE_C-1:0] tile_cur;
  logic [TILE_C-1:0]        x_cur;
  logic [TILE_R-1:0]        p;

  assign cfg_ok = (state_q == S_IDLE) && ({1'b0, cfg_addr_i} < (AW+1)'(T));

  // Shared tile product: each output row is the parity of (tile row AND x slice).
  always_comb begin
    tile_cur = tile_q[idx_q];
    x_cur    = x_q[TILE_C*ct_q +: TILE_C];
    p        = '0;
    for (int r = 0; r < TILE_R; r++) begin
      p[r] = ^(tile_cur[TILE_C*r +: TILE_C] & x_cur);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      rt_q        <= '0;
      ct_q        <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      x_q         <= '0;
      for (int i = 0; i < T; i++) tile_q[i] <= '0;
    end else begin
      cfg_err_q <= cfg_we_i && !cfg_ok;
      if (cfg_we_i && cfg_ok) tile_q[cfg_addr_i] <= cfg_wdata_i;
      case (state_q)
        S_IDLE: begin
          if (vec_valid_i) begin
            x_q     <= vec_data_i;
            rt_q    <= '0;
            ct_q    <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          idx_q <= idx_q + 1'b1;
          if (ct_q == CW'(COL_TILES-1)) begin
            res_data_q[TILE_R*rt_q +: TILE_R] <= acc_q ^ p;
            acc_q <= '0;
            ct_q  <= '0;
            if (rt_q == RW'(ROW_TILES-1)) begin
              state_q     <= S_DONE;
              res_valid_q <= 1'b1;
            end else begin
              rt_q <= rt_q + 1'b1;
            end
          end else begin
            acc_q <= acc_q ^ p;
            ct_q  <= ct_q + 1'b1;
          end
        end
        S_DONE: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign vec_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign cfg_err_o   = cfg_err_q;

`ifdef MV_STATS_EN
  logic [15:0] stat_cnt_q;
  logic [15:0] stat_rej_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stat_cnt_q <= '0;
      stat_rej_q <= '0;
    end else begin
      if (res_valid_q && res_ready_i && stat_cnt_q != 16'hFFFF) stat_cnt_q <= stat_cnt_q + 1'b1;
      if (cfg_we_i && !cfg_ok && stat_rej_q != 16'hFFFF) stat_rej_q <= stat_rej_q + 1'b1;
    end
  end

  assign stat_cnt_o = stat_cnt_q;
  assign stat_rej_o = stat_rej_q;
`endif

endmodule

// File: tb/tb_gf2_tile_mv_ctrl.sv
// Directed bench for gf2_tile_mv_ctrl: default instance plus a small non-power-of-two instance for address rejection.
module tb_gf2_tile_mv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_err;
  logic        vec_valid;
  logic        vec_ready;
  logic [31:0] vec_data;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic        busy;

  logic        cfg2_we;
  logic [1:0]  cfg2_addr;
  logic [3:0]  cfg2_wdata;
  logic        cfg2_err;
  logic        vec2_ready;
  logic        res2_valid;
  logic [1:0]  res2_data;
  logic        busy2;

`ifdef MV_STATS_EN
  logic [15:0] stat_cnt, stat_rej, stat2_cnt, stat2_rej;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gf2_tile_mv_ctrl u_dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata), .cfg_err_o(cfg_err),
    .vec_valid_i(vec_valid), .vec_ready_o(vec_ready), .vec_data_i(vec_data),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
`ifdef MV_STATS_EN
    .busy_o(busy), .stat_cnt_o(stat_cnt), .stat_rej_o(stat_rej)
`else
    .busy_o(busy)
`endif
  );

  gf2_tile_mv_ctrl #(.TILE_R(2), .TILE_C(2), .ROW_TILES(1), .COL_TILES(3)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst_n),
    .cfg_we_i(cfg2_we), .cfg_addr_i(cfg2_addr), .cfg_wdata_i(cfg2_wdata), .cfg_err_o(cfg2_err),
    .vec_valid_i(1'b0), .vec_ready_o(vec2_ready), .vec_data_i(6'h00),
    .res_valid_o(res2_valid), .res_ready_i(1'b1), .res_data_o(res2_data),
`ifdef MV_STATS_EN
    .busy_o(busy2), .stat_cnt_o(stat2_cnt), .stat_rej_o(stat2_rej)
`else
    .busy_o(busy2)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_tile(input logic [2:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic accept(input string tag, input logic [31:0] x);
    chk({tag, "_rdy"}, vec_ready, 1'b1);
    vec_valid = 1'b1; vec_data = x;
    tick();
    vec_valid = 1'b0;
  endtask

  // Waits for res_valid; start is the number of edges already spent since accept.
  task automatic wait_res(input string tag, input int start, input logic [7:0] exp);
    int cnt = start;
    while (!res_valid && cnt < 50) begin
      tick();
      cnt++;
    end
    chk({tag, "_lat"}, cnt, 8);
    chk({tag, "_y"}, res_data, exp);
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_idle"}, {busy, vec_ready, res_valid}, 3'b010);
    chk({tag, "_keep"}, res_data, exp);
  endtask

  task automatic run(input string tag, input logic [31:0] x, input logic [7:0] exp);
    accept(tag, x);
    wait_res(tag, 0, exp);
    pop(tag, exp);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    vec_valid = 1'b0; vec_data = '0; res_ready = 1'b0;
    cfg2_we = 1'b0; cfg2_addr = '0; cfg2_wdata = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_state", {busy, vec_ready, res_valid, cfg_err}, 4'b0100);
    chk("rst_y", res_data, 8'h00);
`ifdef MV_STATS_EN
    chk("rst_stat_cnt", stat_cnt, 16'd0);
`endif

    run("zeroH", 32'hFFFF_FFFF, 8'h00);
`ifdef MV_STATS_EN
    chk("stat_cnt_one", stat_cnt, 16'd1);
`endif

    for (int i = 0; i < 8; i++) wr_tile(3'(i), 32'h0101_0101);
    chk("cfg_ok_noerr", cfg_err, 1'b0);
    run("col0", 32'h0000_0001, 8'hFF);
    run("col0_8", 32'h0000_0101, 8'h00);

    wr_tile(3'd5, 32'hFFFF_FFFF);
    run("t5_x300", 32'h0000_0300, 8'h0F);
    run("t5_x100", 32'h0000_0100, 8'hFF);

    // Hold the result under backpressure; a write while in DONE is also rejected.
    accept("hold", 32'h0000_0200);
    wait_res("hold", 0, 8'hF0);
    begin
      logic stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
        if (i == 4) begin cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wdata = '0; end
        tick();
        cfg_we = 1'b0;
        if (i == 4) chk("done_wr_err", cfg_err, 1'b1);
        if (!(res_valid && res_data == 8'hF0 && !vec_ready && busy)) stable = 1'b0;
      end
      chk("hold_stable", stable, 1'b1);
    end
    pop("hold", 8'hF0);
    tick();
    run("after_done_wr", 32'h0000_0002, 8'h00);

    // Write during RUN: dropped, one-cycle error pulse, old H used now and later.
    accept("runwr", 32'h0000_0001);
    tick(); tick();
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 32'h0;
    tick();
    cfg_we = 1'b0;
    chk("runwr_err", cfg_err, 1'b1);
    tick();
    chk("runwr_err_clr", cfg_err, 1'b0);
    wait_res("runwr", 4, 8'hFF);
    pop("runwr", 8'hFF);
    tick();
    run("runwr_old", 32'h0000_0001, 8'hFF);

    // Same-edge tile write and accept: the run must see the new tile 0.
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 32'h0;
    accept("same", 32'h0000_0001);
    cfg_we = 1'b0;
    wait_res("same", 0, 8'hF0);
    pop("same", 8'hF0);
    tick();

    // Address beyond T on the 3-tile instance.
    cfg2_we = 1'b1; cfg2_addr = 2'd3; cfg2_wdata = 4'hF;
    tick();
    cfg2_we = 1'b0;
    chk("addr_oob_err", cfg2_err, 1'b1);
    cfg2_we = 1'b1; cfg2_addr = 2'd2;
    tick();
    cfg2_we = 1'b0;
    chk("addr_inb_ok", cfg2_err, 1'b0);

    // Reset mid-run aborts and clears the tiles.
    accept("abort", 32'h0000_0001);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_state", {busy, vec_ready, res_valid}, 3'b010);
    chk("abort_y", res_data, 8'h00);
`ifdef MV_STATS_EN
    chk("abort_stat_cnt", stat_cnt, 16'd0);
`endif
    repeat (10) tick();
    chk("abort_no_res", res_valid, 1'b0);
    run("cleared", 32'h0000_0001, 8'h00);
`ifdef MV_STATS_EN
    chk("cleared_stat_cnt", stat_cnt, 16'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
